// File: rtl/mu0_pkg.sv
// mu0_pkg
// Shared types for the MU0 boot controller slice.
//   opcode_t      - MU0 instruction opcodes (top nibble of an instruction word)
//   boot_state_t  - boot controller sequencer states
//   bus_owner_t   - which source currently drives the RAM port
package mu0_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'd0,
        OP_STO = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_JMP = 4'd4,
        OP_JGE = 4'd5,
        OP_JNE = 4'd6,
        OP_STP = 4'd7
    } opcode_t;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } boot_state_t;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_LOADER = 2'd1,
        OWN_CPU    = 2'd2
    } bus_owner_t;

endpackage

// File: rtl/mu0_bus_mux.sv
// mu0_bus_mux
// Combinational two-source RAM port mux. The owner select picks the loader,
// the CPU, or nobody; with no owner the port is idle (no read, no write).
// Ports:
//   owner_i                                     - bus owner select
//   ld_address_i, ld_write_i, ld_writedata_i    - loader write request
//   cpu_address_i, cpu_read_i, cpu_write_i,
//   cpu_writedata_i                             - CPU bus request
//   mem_address_o, mem_read_o, mem_write_o,
//   mem_writedata_o                             - RAM port
module mu0_bus_mux
    import mu0_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  bus_owner_t          owner_i,
    input  logic [ADDR_W-1:0]   ld_address_i,
    input  logic                ld_write_i,
    input  logic [DATA_W-1:0]   ld_writedata_i,
    input  logic [ADDR_W-1:0]   cpu_address_i,
    input  logic                cpu_read_i,
    input  logic                cpu_write_i,
    input  logic [DATA_W-1:0]   cpu_writedata_i,
    output logic [ADDR_W-1:0]   mem_address_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic [DATA_W-1:0]   mem_writedata_o
);

    always_comb begin
        mem_address_o   = '0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        mem_writedata_o = '0;
        case (owner_i)
            OWN_LOADER: begin
                mem_address_o   = ld_address_i;
                mem_write_o     = ld_write_i;
                mem_writedata_o = ld_writedata_i;
            end
            OWN_CPU: begin
                mem_address_o   = cpu_address_i;
                mem_read_o      = cpu_read_i;
                mem_write_o     = cpu_write_i;
                mem_writedata_o = cpu_writedata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mu0_boot_controller.sv
// mu0_boot_controller
// Owns the MU0 CPU reset and the single RAM port. After reset it streams a
// program image into RAM with the CPU held in reset, then releases the CPU
// and watches it until it halts (STP) or a cycle timeout fires.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   load_valid/ready/data/last       - program image stream
//   reload                           - from DONE/TIMEOUT, restart loading
//   cpu_rst                          - registered reset to the CPU
//   cpu_running, cpu_address, cpu_read, cpu_write, cpu_writedata
//                                    - CPU status and bus request
//   cpu_readdata                     - read data back to the CPU
//   mem_address/read/write/writedata/readdata - RAM port
//   done, timed_out                  - halt status
//   words_loaded, cycle_count        - image size and RUN cycle count
module mu0_boot_controller
    import mu0_pkg::*;
#(
    parameter int              ADDR_W         = 12,
    parameter int              DATA_W         = 16,
    parameter longint unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [DATA_W-1:0]   load_data,
    input  logic                load_last,
    input  logic                reload,
    output logic                cpu_rst,
    input  logic                cpu_running,
    input  logic [ADDR_W-1:0]   cpu_address,
    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [DATA_W-1:0]   cpu_writedata,
    output logic [DATA_W-1:0]   cpu_readdata,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                done,
    output logic                timed_out,
    output logic [ADDR_W:0]     words_loaded,
    output logic [31:0]         cycle_count
);

    // Value of cycle_count on the edge that must trip the timeout.
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    boot_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
    logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
    logic [31:0]         cycle_count_q, cycle_count_d;
    logic                done_q, done_d;
    logic                timed_out_q, timed_out_d;
    logic                cpu_rst_q, cpu_rst_d;

    logic                handshake;
    bus_owner_t          bus_owner;

    assign load_ready = (state_q == LOAD);
    assign handshake  = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= LOAD;
            load_addr_q    <= '0;
            words_loaded_q <= '0;
            cycle_count_q  <= '0;
            done_q         <= 1'b0;
            timed_out_q    <= 1'b0;
            cpu_rst_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            load_addr_q    <= load_addr_d;
            words_loaded_q <= words_loaded_d;
            cycle_count_q  <= cycle_count_d;
            done_q         <= done_d;
            timed_out_q    <= timed_out_d;
            cpu_rst_q      <= cpu_rst_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_addr_d    = load_addr_q;
        words_loaded_d = words_loaded_q;
        cycle_count_d  = cycle_count_q;
        done_d         = done_q;
        timed_out_d    = timed_out_q;

        case (state_q)
            LOAD: begin
                if (handshake) begin
                    load_addr_d    = load_addr_q + 1'b1;
                    words_loaded_d = words_loaded_q + 1'b1;
                    // Writing the top address means the RAM is full.
                    if (load_last || (load_addr_q == {ADDR_W{1'b1}})) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cycle_count_d = cycle_count_q + 32'd1;
                // A halt seen on the same edge as the timeout wins.
                if (!cpu_running) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (cycle_count_q == TIMEOUT_LAST) begin
                    state_d     = TIMEOUT;
                    timed_out_d = 1'b1;
                end
            end
            DONE, TIMEOUT: begin
                if (reload) begin
                    state_d        = LOAD;
                    load_addr_d    = '0;
                    words_loaded_d = '0;
                    cycle_count_d  = '0;
                    done_d         = 1'b0;
                    timed_out_d    = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase

        // Derived from the next state so cpu_rst is already low in the
        // first RUN cycle and already high in the first LOAD/TIMEOUT cycle.
        cpu_rst_d = !((state_d == RUN) || (state_d == DONE));
    end

    // The RAM port is released during the reset cycle itself so a CPU store
    // that coincides with rst never lands in memory.
    always_comb begin
        if (rst) begin
            bus_owner = OWN_NONE;
        end else begin
            case (state_q)
                LOAD:    bus_owner = OWN_LOADER;
                RUN:     bus_owner = OWN_CPU;
                default: bus_owner = OWN_NONE;
            endcase
        end
    end

    mu0_bus_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bus_mux (
        .owner_i         (bus_owner),
        .ld_address_i    (load_addr_q),
        .ld_write_i      (load_valid),
        .ld_writedata_i  (load_data),
        .cpu_address_i   (cpu_address),
        .cpu_read_i      (cpu_read),
        .cpu_write_i     (cpu_write),
        .cpu_writedata_i (cpu_writedata),
        .mem_address_o   (mem_address),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .mem_writedata_o (mem_writedata)
    );

    assign cpu_readdata = mem_readdata;
    assign cpu_rst      = cpu_rst_q;
    assign done         = done_q;
    assign timed_out    = timed_out_q;
    assign words_loaded = words_loaded_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_mu0_boot_controller.sv
// tb_mu0_boot_controller
// Bench for mu0_boot_controller with a behavioural two-cycle-per-instruction
// MU0 CPU and a combinational-read RAM. RAM writes are logged by a monitor
// and compared against an expected-write scoreboard built while driving.
module tb_mu0_boot_controller;
    import mu0_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    logic                clk;
    logic                rst;
    logic                load_valid;
    logic                load_ready;
    logic [DATA_W-1:0]   load_data;
    logic                load_last;
    logic                reload;
    logic                cpu_rst;
    logic                cpu_running;
    logic [ADDR_W-1:0]   cpu_address;
    logic                cpu_read;
    logic                cpu_write;
    logic [DATA_W-1:0]   cpu_writedata;
    logic [DATA_W-1:0]   cpu_readdata;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_read;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic [DATA_W-1:0]   mem_readdata;
    logic                done;
    logic                timed_out;
    logic [ADDR_W:0]     words_loaded;
    logic [31:0]         cycle_count;

    int n_checks = 0;
    int n_errors = 0;

    mu0_boot_controller #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_last     (load_last),
        .reload        (reload),
        .cpu_rst       (cpu_rst),
        .cpu_running   (cpu_running),
        .cpu_address   (cpu_address),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .mem_address   (mem_address),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .done          (done),
        .timed_out     (timed_out),
        .words_loaded  (words_loaded),
        .cycle_count   (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    initial for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    assign mem_readdata = ram[mem_address];
    always @(posedge clk) if (mem_write) ram[mem_address] <= mem_writedata;

    // ---------------- MU0 CPU model ----------------
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir, acc;
    logic              phase;   // 0 = fetch, 1 = execute
    logic              running;
    opcode_t           op;
    assign op          = opcode_t'(ir[15:12]);
    assign cpu_running = running;

    always_comb begin
        cpu_address   = phase ? ir[11:0] : pc;
        cpu_read      = 1'b0;
        cpu_write     = 1'b0;
        cpu_writedata = acc;
        if (running && !cpu_rst) begin
            if (!phase) cpu_read = 1'b1;
            else if (op == OP_STO) cpu_write = 1'b1;
            else if (op == OP_LDA || op == OP_ADD || op == OP_SUB) cpu_read = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (cpu_rst) begin
            pc <= '0; acc <= '0; ir <= '0; phase <= 1'b0; running <= 1'b1;
        end else if (running) begin
            if (!phase) begin
                ir    <= cpu_readdata;
                pc    <= pc + 1'b1;
                phase <= 1'b1;
            end else begin
                phase <= 1'b0;
                case (op)
                    OP_LDA: acc <= cpu_readdata;
                    OP_ADD: acc <= acc + cpu_readdata;
                    OP_SUB: acc <= acc - cpu_readdata;
                    OP_JMP: pc  <= ir[11:0];
                    OP_JGE: if (!acc[15]) pc <= ir[11:0];
                    OP_JNE: if (acc != 0) pc <= ir[11:0];
                    OP_STP: running <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] obs_q[$];
    int n_writes = 0;
    int n_hs = 0;

    always @(posedge clk) begin
        if (mem_write) begin
            obs_q.push_back({mem_address, mem_writedata});
            n_writes <= n_writes + 1;
        end
        if (load_valid && load_ready && !rst) n_hs <= n_hs + 1;
    end

    logic [ADDR_W-1:0] sb_addr;   // next expected loader address

    task automatic load_word(input logic [DATA_W-1:0] d, input logic last);
        load_valid = 1'b1; load_data = d; load_last = last;
        n_checks++;
        if (load_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL load_ready_before_hs: got %b want 1", load_ready);
        end
        exp_q.push_back({sb_addr, d});
        sb_addr = sb_addr + 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic wait_halt(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done || timed_out) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic compare_writes(input string tag);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL %s_write_count: got %0d want %0d", tag, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL %s_write[%0d]: got addr=%h data=%h want addr=%h data=%h", tag, i,
                         obs_q[i][27:16], obs_q[i][15:0], exp_q[i][27:16], exp_q[i][15:0]);
            end
        end
        $display("%s: %0d RAM writes compared", tag, exp_q.size());
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic do_reload(input string tag);
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        n_checks++;
        if (done !== 1'b0 || timed_out !== 1'b0 || load_ready !== 1'b1 || cpu_rst !== 1'b1 ||
            cycle_count !== 32'd0 || words_loaded !== '0) begin
            n_errors++;
            $display("FAIL %s_reload: got done=%b to=%b rdy=%b crst=%b cyc=%0d wl=%0d want 0 0 1 1 0 0",
                     tag, done, timed_out, load_ready, cpu_rst, cycle_count, words_loaded);
        end
        obs_q.delete(); exp_q.delete(); sb_addr = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if (load_ready !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || timed_out !== 1'b0 ||
            words_loaded !== '0 || cycle_count !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_state: got rdy=%b crst=%b done=%b to=%b wl=%0d cyc=%0d want 1 1 0 0 0 0",
                     load_ready, cpu_rst, done, timed_out, words_loaded, cycle_count);
        end
        @(posedge clk); #1;
        n_checks++;
        if (load_ready !== 1'b1 || mem_write !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got rdy=%b wr=%b want 1 0", load_ready, mem_write);
        end
        obs_q.delete(); sb_addr = '0;
        $display("test_reset: done");
    endtask

    task automatic test_single_stp();
        load_word(16'h7000, 1'b1);
        n_checks++;
        if (cpu_rst !== 1'b0 || load_ready !== 1'b0 || words_loaded !== 13'd1) begin
            n_errors++;
            $display("FAIL stp_run_entry: got crst=%b rdy=%b wl=%0d want 0 0 1", cpu_rst, load_ready, words_loaded);
        end
        wait_halt(50);
        n_checks++;
        if (done !== 1'b1 || timed_out !== 1'b0 || cycle_count !== 32'd3 || cpu_rst !== 1'b0) begin
            n_errors++;
            $display("FAIL stp_done: got done=%b to=%b cyc=%0d crst=%b want 1 0 3 0", done, timed_out, cycle_count, cpu_rst);
        end
        n_checks++;
        if (ram[0] !== 16'h7000) begin
            n_errors++;
            $display("FAIL stp_mem0: got %h want 7000", ram[0]);
        end
        compare_writes("test_single_stp");
    endtask

    task automatic test_add_program();
        logic [15:0] prog [6];
        prog = '{16'h0004, 16'h2005, 16'h1006, 16'h7000, 16'h0003, 16'h0004};
        do_reload("add");
        for (int i = 0; i < 6; i++) load_word(prog[i], i == 5);
        exp_q.push_back({12'd6, 16'd7});   // STO 6 of 3+4
        wait_halt(100);
        n_checks++;
        if (done !== 1'b1 || cycle_count !== 32'd9 || words_loaded !== 13'd6) begin
            n_errors++;
            $display("FAIL add_done: got done=%b cyc=%0d wl=%0d want 1 9 6", done, cycle_count, words_loaded);
        end
        n_checks++;
        if (ram[6] !== 16'h0007) begin
            n_errors++;
            $display("FAIL add_mem6: got %h want 0007", ram[6]);
        end
        compare_writes("test_add_program");
    endtask

    task automatic test_toggle_valid();
        logic [15:0] prog [4];
        int hs0;
        prog = '{16'h7000, 16'h1111, 16'h2222, 16'h3333};
        do_reload("toggle");
        hs0 = n_hs;
        for (int i = 0; i < 4; i++) begin
            load_word(prog[i], i == 3);
            if (i != 3) begin @(posedge clk); #1; end   // idle cycle with valid low
        end
        n_checks++;
        if (words_loaded !== 13'(n_hs - hs0) || words_loaded !== 13'd4) begin
            n_errors++;
            $display("FAIL toggle_count: got wl=%0d hs=%0d want 4 4", words_loaded, n_hs - hs0);
        end
        wait_halt(50);
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL toggle_done: got %b want 1", done);
        end
        compare_writes("test_toggle_valid");
    endtask

    task automatic test_timeout();
        do_reload("timeout");
        load_word(16'h4000, 1'b1);
        wait_halt(300);
        n_checks++;
        if (timed_out !== 1'b1 || done !== 1'b0 || cycle_count !== 32'd100 || cpu_rst !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_state: got to=%b done=%b cyc=%0d crst=%b want 1 0 100 1",
                     timed_out, done, cycle_count, cpu_rst);
        end
        compare_writes("test_timeout");
        load_valid = 1'b1; load_data = 16'hDEAD;   // bus must stay quiet
        repeat (5) @(posedge clk);
        #1 load_valid = 1'b0;
        n_checks++;
        if (obs_q.size() != 0 || cycle_count !== 32'd100) begin
            n_errors++;
            $display("FAIL timeout_frozen: got writes=%0d cyc=%0d want 0 100", obs_q.size(), cycle_count);
        end
        $display("test_timeout: done");
    endtask

    task automatic test_rst_mid_run();
        int seen, wbefore;
        logic [15:0] prog [5];
        prog = '{16'h0004, 16'h1005, 16'h4001, 16'h0000, 16'h1234};
        do_reload("rstrun");
        for (int i = 0; i < 5; i++) load_word(prog[i], i == 4);
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            if (cpu_write) seen++;
            if (seen < 2) begin @(posedge clk); #1; end
        end
        n_checks++;
        if (seen != 2 || ram[5] !== 16'h1234) begin
            n_errors++;
            $display("FAIL rstrun_loop: got stores=%0d mem5=%h want 2 1234", seen, ram[5]);
        end
        wbefore = n_writes;
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_write !== 1'b0) begin
            n_errors++;
            $display("FAIL rstrun_write_in_rst: got %b want 0", mem_write);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (load_ready !== 1'b1 || cpu_rst !== 1'b1 || cycle_count !== 32'd0 || words_loaded !== '0) begin
            n_errors++;
            $display("FAIL rstrun_after: got rdy=%b crst=%b cyc=%0d wl=%0d want 1 1 0 0",
                     load_ready, cpu_rst, cycle_count, words_loaded);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (n_writes != wbefore) begin
            n_errors++;
            $display("FAIL rstrun_no_write: got %0d writes want 0", n_writes - wbefore);
        end
        obs_q.delete(); exp_q.delete(); sb_addr = '0;
        $display("test_rst_mid_run: done");
    endtask

    task automatic test_fill_ram();
        int nobs;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            load_word((i == 0) ? 16'h7000 : 16'(i), 1'b0);
        end
        n_checks++;
        if (load_ready !== 1'b0 || cpu_rst !== 1'b0 || words_loaded !== 13'd4096) begin
            n_errors++;
            $display("FAIL fill_run_entry: got rdy=%b crst=%b wl=%0d want 0 0 4096", load_ready, cpu_rst, words_loaded);
        end
        nobs = obs_q.size();
        load_valid = 1'b1; load_data = 16'hBEEF;
        @(posedge clk); #1;
        load_valid = 1'b0;
        n_checks++;
        if (obs_q.size() != nobs || words_loaded !== 13'd4096) begin
            n_errors++;
            $display("FAIL fill_extra_word: got writes=%0d wl=%0d want %0d 4096", obs_q.size(), words_loaded, nobs);
        end
        wait_halt(50);
        n_checks++;
        if (done !== 1'b1 || cycle_count !== 32'd3 || ram[12'hFFF] !== 16'h0FFF) begin
            n_errors++;
            $display("FAIL fill_done: got done=%b cyc=%0d memFFF=%h want 1 3 0fff", done, cycle_count, ram[12'hFFF]);
        end
        compare_writes("test_fill_ram");
        do_reload("fill");
        $display("test_fill_ram: done");
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0; reload = 1'b0;
        sb_addr = '0;
        test_reset();
        test_single_stp();
        test_add_program();
        test_toggle_valid();
        test_timeout();
        test_rst_mid_run();
        test_fill_ram();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
